// File: rtl/slc3_pkg.sv
// Shared types and widths for the SLC-3 memory responder slice.
//   WORD_W      - datapath word width (MAR, MDR, SRAM data bus)
//   SRAM_ADDR_W - external SRAM address width
//   mem_state_t - responder FSM states
package slc3_pkg;

  localparam int unsigned WORD_W      = 16;
  localparam int unsigned SRAM_ADDR_W = 20;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_wait_counter.sv
// Down-counter that times the SRAM strobe window of one access.
// Ports:
//   clk        - system clock
//   reset      - synchronous, active-high reset (counter cleared)
//   load       - load load_value this cycle (has priority over decrement)
//   load_value - value loaded on load
//   decrement  - count down by one; saturates at zero
//   zero       - counter value is zero
module mem_wait_counter #(
  parameter int unsigned CNT_W = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             decrement,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_value;
    end else if (decrement && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_responder.sv
// Bridges the datapath memory request (MEM_EN/WE/MAR/MDR) to an asynchronous
// SRAM with a fixed number of strobe cycles, then returns a one-cycle ready.
// Ports:
//   clk, reset              - clock and synchronous active-high reset
//   MEM_EN, WE, MAR, MDR    - request level, direction, word address, write data
//   MDR_In                  - read data, held until the next read completes
//   R                       - one-cycle completion pulse
//   busy                    - FSM is not in IDLE
//   sram_addr               - {4'h0, latched MAR}
//   sram_dq_in/out/oe       - split SRAM data bus
//   sram_ce_n/oe_n/we_n     - active-low SRAM strobes
// Every output comes straight from a register; inputs are only sampled in IDLE.
module mem_responder
  import slc3_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   MEM_EN,
  input  logic                   WE,
  input  logic [WORD_W-1:0]      MAR,
  input  logic [WORD_W-1:0]      MDR,
  output logic [WORD_W-1:0]      MDR_In,
  output logic                   R,
  output logic                   busy,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  input  logic [WORD_W-1:0]      sram_dq_in,
  output logic [WORD_W-1:0]      sram_dq_out,
  output logic                   sram_dq_oe,
  output logic                   sram_ce_n,
  output logic                   sram_oe_n,
  output logic                   sram_we_n
);

  if (WAIT_CYCLES < 1) begin : g_bad_wait_cycles
    $fatal(1, "mem_responder: WAIT_CYCLES must be >= 1");
  end

  localparam int unsigned CntW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(WAIT_CYCLES - 1);

  mem_state_t        state_q;
  logic [WORD_W-1:0] addr_q;
  logic [WORD_W-1:0] dq_out_q;
  logic [WORD_W-1:0] mdr_in_q;
  logic              we_q;
  logic              r_q;
  logic              dq_oe_q;
  logic              ce_n_q;
  logic              oe_n_q;
  logic              we_n_q;

  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;

  assign cnt_load = (state_q == IDLE) && MEM_EN;
  assign cnt_dec  = (state_q == ACCESS);

  mem_wait_counter #(
    .CNT_W (CntW)
  ) u_wait_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (CntLoad),
    .decrement  (cnt_dec),
    .zero       (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      dq_out_q <= '0;
      mdr_in_q <= '0;
      we_q     <= 1'b0;
      r_q      <= 1'b0;
      dq_oe_q  <= 1'b0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          r_q <= 1'b0;
          if (MEM_EN) begin
            state_q  <= ACCESS;
            addr_q   <= MAR;
            dq_out_q <= MDR;
            we_q     <= WE;
            ce_n_q   <= 1'b0;
            oe_n_q   <= WE;
            we_n_q   <= ~WE;
            dq_oe_q  <= WE;
          end
        end
        ACCESS: begin
          if (cnt_zero) begin
            state_q <= DONE;
            r_q     <= 1'b1;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            // Read data is still valid while oe_n is low at this edge.
            if (!we_q) begin
              mdr_in_q <= sram_dq_in;
            end
          end
        end
        DONE: begin
          // Write data stays driven through DONE for SRAM hold time.
          state_q <= IDLE;
          r_q     <= 1'b0;
          dq_oe_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign MDR_In      = mdr_in_q;
  assign R           = r_q;
  assign busy        = (state_q != IDLE);
  assign sram_addr   = {{(SRAM_ADDR_W - WORD_W){1'b0}}, addr_q};
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_ce_n   = ce_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_we_n   = we_n_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a WAIT_CYCLES=2 instance checked throughout against
// a transaction-level memory model, plus a WAIT_CYCLES=1 instance sharing the
// same inputs that is checked only in its own directed step.
module tb_mem_responder;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_en;
  logic        we;
  logic [15:0] mar;
  logic [15:0] mdr;
  logic [15:0] dq_in;

  logic [15:0] mdr_in, dq_out;
  logic [19:0] addr;
  logic        r, busy, dq_oe, ce_n, oe_n, we_n;

  logic [15:0] mdr_in1, dq_out1;
  logic [19:0] addr1;
  logic        r1, busy1, dq_oe1, ce_n1, oe_n1, we_n1;

  int checks = 0;
  int errors = 0;

  logic [15:0] ref_mem [logic [15:0]];
  logic [15:0] exp_mdr_in;

  logic        sram_init;
  logic [15:0] sram [65536];

  mem_responder #(
    .WAIT_CYCLES (W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .MEM_EN      (mem_en),
    .WE          (we),
    .MAR         (mar),
    .MDR         (mdr),
    .MDR_In      (mdr_in),
    .R           (r),
    .busy        (busy),
    .sram_addr   (addr),
    .sram_dq_in  (dq_in),
    .sram_dq_out (dq_out),
    .sram_dq_oe  (dq_oe),
    .sram_ce_n   (ce_n),
    .sram_oe_n   (oe_n),
    .sram_we_n   (we_n)
  );

  mem_responder #(
    .WAIT_CYCLES (1)
  ) dut1 (
    .clk         (clk),
    .reset       (reset),
    .MEM_EN      (mem_en),
    .WE          (we),
    .MAR         (mar),
    .MDR         (mdr),
    .MDR_In      (mdr_in1),
    .R           (r1),
    .busy        (busy1),
    .sram_addr   (addr1),
    .sram_dq_in  (dq_in),
    .sram_dq_out (dq_out1),
    .sram_dq_oe  (dq_oe1),
    .sram_ce_n   (ce_n1),
    .sram_oe_n   (oe_n1),
    .sram_we_n   (we_n1)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM attached to the main instance; unwritten words read a ^ 5A5A.
  always @(posedge clk) begin
    if (sram_init) begin
      for (int i = 0; i < 65536; i++) sram[i] <= 16'(i) ^ 16'h5A5A;
    end else if (!ce_n && !we_n) begin
      sram[addr[15:0]] <= dq_out;
    end
  end

  assign dq_in = !oe_n ? sram[addr[15:0]] : 16'hDEAD;

  function automatic logic [15:0] ref_read(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : (a ^ 16'h5A5A);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered and left at the falling edge of an IDLE cycle.
  task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d,
                        input logic scramble);
    chk("idle_busy", busy, 0);
    chk("idle_r", r, 0);
    chk("idle_ce_n", ce_n, 1);
    chk("idle_dq_oe", dq_oe, 0);
    mem_en = 1'b1; we = w; mar = a; mdr = d;
    for (int c = 1; c <= W; c++) begin
      @(negedge clk);
      chk("acc_busy", busy, 1);
      chk("acc_r", r, 0);
      chk("acc_ce_n", ce_n, 0);
      chk("acc_oe_n", oe_n, w);
      chk("acc_we_n", we_n, !w);
      chk("acc_dq_oe", dq_oe, w);
      chk("acc_addr", addr, {4'h0, a});
      if (w) chk("acc_dq_out", dq_out, d);
      if (scramble) begin
        mem_en = 1'($urandom_range(0, 1));
        we     = 1'($urandom_range(0, 1));
        mar    = 16'($urandom);
        mdr    = 16'($urandom);
      end else begin
        mem_en = 1'b0;
      end
    end
    @(negedge clk);
    if (!w) exp_mdr_in = ref_read(a);
    else    ref_mem[a] = d;
    chk("done_r", r, 1);
    chk("done_busy", busy, 1);
    chk("done_ce_n", ce_n, 1);
    chk("done_oe_n", oe_n, 1);
    chk("done_we_n", we_n, 1);
    chk("done_dq_oe", dq_oe, w);
    chk("done_addr", addr, {4'h0, a});
    if (w) chk("done_dq_out", dq_out, d);
    chk("done_mdr_in", mdr_in, exp_mdr_in);
    mem_en = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int          rcount;
    logic [15:0] sampled;
    reset = 1'b1; sram_init = 1'b1;
    mem_en = 1'b0; we = 1'b0; mar = '0; mdr = '0;
    exp_mdr_in = '0;
    @(negedge clk);
    sram_init = 1'b0;
    @(negedge clk);
    chk("rst_ce_n", ce_n, 1);
    chk("rst_oe_n", oe_n, 1);
    chk("rst_we_n", we_n, 1);
    chk("rst_r", r, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mdr_in", mdr_in, 16'h0000);
    chk("rst_dq_oe", dq_oe, 0);
    chk("rst_dq_out", dq_out, 0);
    chk("rst_addr", addr, 0);
    reset = 1'b0;

    // Write then read back, then a read with inputs churning mid-access.
    access(1'b1, 16'h3000, 16'hBEEF, 1'b0);
    access(1'b0, 16'h3000, 16'h0000, 1'b0);
    chk("rd_beef", mdr_in, 16'hBEEF);
    access(1'b0, 16'h3000, 16'h0000, 1'b1);

    // MEM_EN held high: exactly two accesses, R in cycles 3 and 7.
    mem_en = 1'b1; we = 1'b0; mar = 16'h3000; rcount = 0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (r) rcount++;
      if (c == 3) begin
        chk("hold_r3", r, 1);
        chk("hold_data1", mdr_in, ref_read(16'h3000));
        mar = 16'h3001;
      end
      if (c == 4) chk("hold_idle4", busy, 0);
      if (c == 5) chk("hold_addr5", addr, 20'h03001);
      if (c == 7) begin
        chk("hold_r7", r, 1);
        chk("hold_data2", mdr_in, ref_read(16'h3001));
        mem_en = 1'b0;
      end
    end
    chk("hold_rcount", rcount, 2);
    exp_mdr_in = ref_read(16'h3001);

    // Reset wins over a simultaneous request.
    reset = 1'b1; mem_en = 1'b1; we = 1'b1;
    @(negedge clk);
    chk("rstpri_busy", busy, 0);
    chk("rstpri_ce_n", ce_n, 1);
    chk("rstpri_mdr_in", mdr_in, 0);
    reset = 1'b0; mem_en = 1'b0;
    exp_mdr_in = '0;
    @(negedge clk);

    // Reset in cycle 2 of a write aborts it with no R.
    mem_en = 1'b1; we = 1'b1; mar = 16'hF00D; mdr = 16'h1111;
    @(negedge clk);
    chk("abort_we_n1", we_n, 0);
    mem_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_we_n3", we_n, 1);
    chk("abort_dq_oe3", dq_oe, 0);
    chk("abort_busy3", busy, 0);
    rcount = r ? 1 : 0;
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (r) rcount++;
    end
    chk("abort_no_r", rcount, 0);

    // WAIT_CYCLES=1 read on the second instance.
    mem_en = 1'b1; we = 1'b0; mar = 16'h4321;
    @(negedge clk);
    chk("w1_oe_n1", oe_n1, 0);
    chk("w1_ce_n1", ce_n1, 0);
    chk("w1_busy1", busy1, 1);
    chk("w1_r1", r1, 0);
    chk("w1_addr1", addr1, 20'h04321);
    sampled = dq_in;
    mem_en = 1'b0;
    @(negedge clk);
    chk("w1_r2", r1, 1);
    chk("w1_oe_n2", oe_n1, 1);
    chk("w1_we_n2", we_n1, 1);
    chk("w1_dq_oe2", dq_oe1, 0);
    chk("w1_data_sampled", mdr_in1, sampled);
    chk("w1_data_ref", mdr_in1, ref_read(16'h4321));
    @(negedge clk);
    chk("w1_r3", r1, 0);
    chk("w1_busy3", busy1, 0);
    chk("w2_r3", r, 1);
    chk("w2_data3", mdr_in, ref_read(16'h4321));
    exp_mdr_in = ref_read(16'h4321);
    @(negedge clk);

    // Random traffic over a small address pool so reads hit earlier writes.
    repeat (40) begin
      access(1'($urandom_range(0, 1)), 16'h3000 + 16'($urandom_range(0, 7)),
             16'($urandom), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin
        mem_en = 1'b0;
        mar    = 16'($urandom);
        @(negedge clk);
        chk("gap_busy", busy, 0);
        chk("gap_mdr_in", mdr_in, exp_mdr_in);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, meaning SRAM strobe cycles per access (legal range >= 1).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port MEM_EN  input  1  memory request level from the datapath control FSM.
REQ-005 SHALL have port WE  input  1  1 = write, 0 = read; sampled with MEM_EN.
REQ-006 SHALL have port MAR  input  16  word address from the datapath.
REQ-007 SHALL have port MDR  input  16  write data from the datapath.
REQ-008 SHALL have port MDR_In  output  16  read data returned to the datapath MDR mux.
REQ-009 SHALL have port R  output  1  ready; one-cycle pulse on access completion.
REQ-010 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.
REQ-011 SHALL have port sram_addr  output  20  SRAM address, equal to {4'h0, latched MAR}.
REQ-012 SHALL have ports sram_dq_in (input, 16), sram_dq_out (output, 16) and sram_dq_oe (output, 1), forming the split SRAM data bus.
REQ-013 SHALL have ports sram_ce_n, sram_oe_n and sram_we_n, each an output of width 1, serving as active-low SRAM strobes.

Function
REQ-014 SHALL implement FSM states IDLE, ACCESS and DONE.
REQ-015 IDLE with MEM_EN=1 SHALL latch MAR, MDR and WE, load the wait counter with WAIT_CYCLES-1, and move to ACCESS.
REQ-016 IDLE with MEM_EN=0 SHALL remain in IDLE, with no SRAM activity.
REQ-017 ACCESS SHALL drive sram_ce_n=0. A read SHALL drive sram_oe_n=0. A write SHALL drive sram_we_n=0 and sram_dq_oe=1, with sram_dq_out set to the latched MDR.
REQ-018 ACCESS SHALL decrement the counter each cycle. At counter 0 it SHALL move to DONE; on a read it SHALL also capture sram_dq_in into MDR_In at that same edge.
REQ-019 DONE SHALL assert R=1 for exactly one cycle, deassert all strobes, and keep sram_dq_oe=1 with data unchanged after a write (hold time). It SHALL then move unconditionally to IDLE.
REQ-020 Latency: with MEM_EN sampled in IDLE at cycle 0, R SHALL be high in cycle WAIT_CYCLES+1.
REQ-021 MEM_EN held high across R SHALL start exactly one new access, sampled in the IDLE cycle following DONE; there SHALL be no duplicate access.
REQ-022 Changes on MEM_EN, WE, MAR or MDR during ACCESS or DONE SHALL be ignored.
REQ-023 MDR_In SHALL hold its value until the next read completes; writes SHALL NOT alter it.
REQ-024 All outputs SHALL decode from registers only, with no combinational path from input to output.
REQ-025 WAIT_CYCLES < 1 SHALL cause an elaboration-time fatal error.

Reset
REQ-026 Reset SHALL force, at the next edge: state IDLE, MDR_In=16'h0000, R=0, busy=0, sram_ce_n/oe_n/we_n=1, sram_dq_oe=0, sram_dq_out=0, sram_addr=0.
REQ-027 Reset during ACCESS or DONE SHALL abort the access. R SHALL NOT pulse for the aborted request, and SRAM contents at the aborted write address are undefined.
REQ-028 Reset SHALL take priority over MEM_EN in the same cycle.

Structure
REQ-029 Shared package slc3_pkg SHALL hold mem_state_t {IDLE, ACCESS, DONE}, WORD_W=16 and SRAM_ADDR_W=20.
REQ-030 The wait counter SHALL be one sub-module, mem_wait_counter, with inputs load, load value and decrement, and a zero flag output.

Verification
REQ-031 Reset held 2 cycles -> all strobes 1, R=0, busy=0, MDR_In=0000, sram_dq_oe=0.
REQ-032 WAIT_CYCLES=2, write MAR=3000 MDR=BEEF -> cycles 1-2 sram_we_n=0, sram_addr=03000, sram_dq_out=BEEF; R=1 in cycle 3. A following read of 3000 -> MDR_In=BEEF when R pulses.
REQ-033 MEM_EN held high with MAR 3000 then 3001 (changed at first R) -> exactly two reads, R pulses in cycles 3 and 7.
REQ-034 Read of 3000 with MAR changed to 1234 in cycle 1 -> sram_addr stays 03000 through DONE.
REQ-035 Reset asserted in cycle 2 of a write -> cycle 3 shows sram_we_n=1, sram_dq_oe=0, busy=0; R never pulses.
REQ-036 WAIT_CYCLES=1, read -> sram_oe_n=0 in cycle 1 only, R=1 in cycle 2, MDR_In equals sram_dq_in as sampled in cycle 1.
